// File: rtl/ni_pkg.sv
// Shared definitions for the local network interface: flit layout,
// flit type encoding and header/body flit builders.
package ni_pkg;

    localparam int FLIT_W    = 17;
    localparam int PAYLOAD_W = 14;
    localparam int ID_W      = 4;
    localparam int LEN_W     = 3;

    localparam int VALID_BIT = 16;
    localparam int TYPE_LSB  = 14;
    localparam int DEST_LSB  = 10;
    localparam int SRC_LSB   = 6;
    localparam int LEN_LSB   = 3;

    typedef enum logic [1:0] {
        FLIT_ILLEGAL = 2'b00,
        FLIT_HEAD    = 2'b01,
        FLIT_BODY    = 2'b10,
        FLIT_TAIL    = 2'b11
    } flit_type_e;

    function automatic logic [FLIT_W-1:0] make_head(input logic [ID_W-1:0]  dest,
                                                    input logic [ID_W-1:0]  src,
                                                    input logic [LEN_W-1:0] len);
        logic [FLIT_W-1:0] f;
        f                      = '0;
        f[VALID_BIT]           = 1'b1;
        f[TYPE_LSB +: 2]       = FLIT_HEAD;
        f[DEST_LSB +: ID_W]    = dest;
        f[SRC_LSB +: ID_W]     = src;
        f[LEN_LSB +: LEN_W]    = len;
        return f;
    endfunction

    function automatic logic [FLIT_W-1:0] make_body(input flit_type_e            ftype,
                                                    input logic [PAYLOAD_W-1:0] payload);
        logic [FLIT_W-1:0] f;
        f                      = '0;
        f[VALID_BIT]           = 1'b1;
        f[TYPE_LSB +: 2]       = ftype;
        f[PAYLOAD_W-1:0]       = payload;
        return f;
    endfunction

endpackage

// File: rtl/ni_rx_fifo.sv
// RX flit FIFO. The router's local output cannot be stalled, so a push into a
// full FIFO is dropped (drop_o) unless a pop frees a slot in the same cycle.
// The head entry is read straight from storage; an empty FIFO presents zero.
module ni_rx_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic [W-1:0] wdata_i,
    input  logic         pop_i,
    output logic [W-1:0] rdata_o,
    output logic         valid_o,
    output logic         drop_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [W-1:0]     mem_q [DEPTH];
    logic [W-1:0]     mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             full;
    logic             push_ok;
    logic             pop_ok;

    // Next-state for storage, pointers and occupancy; pointers wrap naturally (power-of-two depth).
    always_comb begin
        full     = (cnt_q == CNT_W'(DEPTH));
        pop_ok   = pop_i && (cnt_q != '0);
        push_ok  = push_i && (!full || pop_ok);
        drop_o   = push_i && full && !pop_ok;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = wdata_i;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push_ok && !pop_ok) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (pop_ok && !push_ok) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // FIFO state registers; reset flushes all entries.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Head presentation straight from storage.
    always_comb begin
        valid_o = (cnt_q != '0);
        rdata_o = valid_o ? mem_q[rd_ptr_q] : '0;
    end

endmodule

// File: rtl/local_network_interface.sv
// PE-side network interface for one mesh node: packetizes PE requests into
// flits for the router local input and buffers ejected flits for the PE.
// Optional RX protocol checker enabled by defining NI_RX_CHECK_EN.
//
// TX FSM states:
//   state   | meaning
//   TX_IDLE | waiting for pe_req_i; dest/len latched on request
//   TX_HEAD | header pending, sent on the first cycle local_full_i is low
//   TX_BODY | body/tail flits pending, one per cycle with pe_valid_i & !local_full_i
module local_network_interface
    import ni_pkg::*;
#(
    parameter logic [3:0] ROUTER_ID = 4'd13,
    parameter int         RX_DEPTH  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pe_req_i,
    input  logic [3:0]  pe_dest_i,
    input  logic [2:0]  pe_len_i,
    output logic        pe_ack_o,
    input  logic [13:0] pe_data_i,
    input  logic        pe_valid_i,
    output logic        pe_ready_o,
    output logic        tx_busy_o,
    input  logic        local_full_i,
    output logic [16:0] local_flit_o,
    input  logic [16:0] local_flit_i,
    output logic [15:0] rx_flit_o,
    output logic        rx_valid_o,
    input  logic        rx_ready_i,
    output logic        rx_drop_o,
    output logic [7:0]  err_cnt_o
);

    typedef enum logic [1:0] {
        TX_IDLE = 2'b00,
        TX_HEAD = 2'b01,
        TX_BODY = 2'b10
    } tx_state_e;

    tx_state_e        state_q, state_d;
    logic [ID_W-1:0]  dest_q, dest_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] rem_q, rem_d;

    // TX next state and flit outputs; the full check is combinational because
    // router credits only update one edge after a flit is accepted.
    always_comb begin
        state_d      = state_q;
        dest_d       = dest_q;
        len_d        = len_q;
        rem_d        = rem_q;
        local_flit_o = '0;
        pe_ack_o     = 1'b0;
        pe_ready_o   = 1'b0;
        case (state_q)
            TX_IDLE: begin
                if (pe_req_i) begin
                    dest_d  = pe_dest_i;
                    len_d   = pe_len_i;
                    rem_d   = pe_len_i;
                    state_d = TX_HEAD;
                end
            end
            TX_HEAD: begin
                if (!local_full_i) begin
                    local_flit_o = make_head(dest_q, ROUTER_ID, len_q);
                    pe_ack_o     = 1'b1;
                    state_d      = (len_q == '0) ? TX_IDLE : TX_BODY;
                end
            end
            TX_BODY: begin
                if (pe_valid_i && !local_full_i) begin
                    local_flit_o = make_body((rem_q == LEN_W'(1)) ? FLIT_TAIL : FLIT_BODY,
                                             pe_data_i);
                    pe_ready_o   = 1'b1;
                    rem_d        = rem_q - LEN_W'(1);
                    if (rem_q == LEN_W'(1)) begin
                        state_d = TX_IDLE;
                    end
                end
            end
            default: begin
                state_d = TX_IDLE;
            end
        endcase
    end

    // TX state registers; reset abandons any packet in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= TX_IDLE;
            dest_q  <= '0;
            len_q   <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            dest_q  <= dest_d;
            len_q   <= len_d;
            rem_q   <= rem_d;
        end
    end

    assign tx_busy_o = (state_q != TX_IDLE);

    ni_rx_fifo #(
        .DEPTH (RX_DEPTH),
        .W     (16)
    ) u_rx_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (local_flit_i[VALID_BIT]),
        .wdata_i (local_flit_i[15:0]),
        .pop_i   (rx_ready_i),
        .rdata_o (rx_flit_o),
        .valid_o (rx_valid_o),
        .drop_o  (rx_drop_o)
    );

`ifdef NI_RX_CHECK_EN
    logic       in_pkt_q, in_pkt_d;
    logic [7:0] err_cnt_q, err_cnt_d;
    logic       rx_bad;

    // Packet framing check on every arriving flit; offending flits are still buffered.
    always_comb begin
        in_pkt_d  = in_pkt_q;
        rx_bad    = 1'b0;
        if (local_flit_i[VALID_BIT]) begin
            case (flit_type_e'(local_flit_i[TYPE_LSB +: 2]))
                FLIT_HEAD: begin
                    rx_bad   = (local_flit_i[DEST_LSB +: ID_W] != ROUTER_ID) || in_pkt_q;
                    in_pkt_d = (local_flit_i[LEN_LSB +: LEN_W] != '0);
                end
                FLIT_BODY: begin
                    rx_bad = !in_pkt_q;
                end
                FLIT_TAIL: begin
                    rx_bad   = !in_pkt_q;
                    in_pkt_d = 1'b0;
                end
                default: begin
                    rx_bad = 1'b1;
                end
            endcase
        end
        err_cnt_d = (rx_bad && (err_cnt_q != 8'hFF)) ? err_cnt_q + 8'd1 : err_cnt_q;
    end

    // Checker state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_pkt_q  <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            in_pkt_q  <= in_pkt_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt_o = err_cnt_q;
`else
    assign err_cnt_o = '0;
`endif

endmodule

// File: tb/tb_local_network_interface.sv
module tb_local_network_interface;

    localparam logic [3:0] RID   = 4'd13;
    localparam int         DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        pe_req_i = 1'b0;
    logic [3:0]  pe_dest_i = '0;
    logic [2:0]  pe_len_i = '0;
    logic        pe_ack_o;
    logic [13:0] pe_data_i = '0;
    logic        pe_valid_i = 1'b0;
    logic        pe_ready_o;
    logic        tx_busy_o;
    logic        local_full_i = 1'b0;
    logic [16:0] local_flit_o;
    logic [16:0] local_flit_i = '0;
    logic [15:0] rx_flit_o;
    logic        rx_valid_o;
    logic        rx_ready_i = 1'b0;
    logic        rx_drop_o;
    logic [7:0]  err_cnt_o;

    always #5 clk = ~clk;

    local_network_interface #(.ROUTER_ID(RID), .RX_DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .pe_req_i     (pe_req_i),
        .pe_dest_i    (pe_dest_i),
        .pe_len_i     (pe_len_i),
        .pe_ack_o     (pe_ack_o),
        .pe_data_i    (pe_data_i),
        .pe_valid_i   (pe_valid_i),
        .pe_ready_o   (pe_ready_o),
        .tx_busy_o    (tx_busy_o),
        .local_full_i (local_full_i),
        .local_flit_o (local_flit_o),
        .local_flit_i (local_flit_i),
        .rx_flit_o    (rx_flit_o),
        .rx_valid_o   (rx_valid_o),
        .rx_ready_i   (rx_ready_i),
        .rx_drop_o    (rx_drop_o),
        .err_cnt_o    (err_cnt_o)
    );

    int          checks = 0;
    int          errors = 0;
    logic [16:0] tx_exp_q [$];
    logic [15:0] mdl_q [$];
    int          mdl_err = 0;
    bit          mdl_in_pkt = 1'b0;
    int          cyc = 0;
    int          head_cyc = 0;
    int          tail_cyc = 0;
    logic [16:0] last_head = '0;
    int          drop_cnt = 0;
    bit          rand_full = 1'b0;
    logic [13:0] cur_pl [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rand_full) local_full_i = ($urandom % 3 == 0);
    end

    // Monitor / scoreboard: samples 2 time units after the falling edge.
    logic [16:0] mon_exp;
    logic [15:0] mon_f;
    bit          mon_pop;
    bit          mon_drop;
    bit          mon_bad;
    always begin
        @(negedge clk);
        #2;
        cyc++;
        if (!rst) begin
            mdl_q.delete();
            mdl_err    = 0;
            mdl_in_pkt = 1'b0;
        end else begin
            if (local_flit_o[16]) begin
                check("tx_full_gate", local_full_i, 0);
                if (tx_exp_q.size() == 0) begin
                    check("tx_unexpected", local_flit_o, 0);
                end else begin
                    mon_exp = tx_exp_q.pop_front();
                    check("tx_flit", local_flit_o, mon_exp);
                end
                check("tx_ack", pe_ack_o, (local_flit_o[15:14] == 2'b01));
                check("tx_ready", pe_ready_o, local_flit_o[15]);
                if (local_flit_o[15:14] == 2'b01) begin
                    head_cyc  = cyc;
                    last_head = local_flit_o;
                end
                if (local_flit_o[15:14] == 2'b11) tail_cyc = cyc;
            end else begin
                check("tx_idle_hs", {pe_ack_o, pe_ready_o}, 0);
            end

            check("err_cnt", err_cnt_o, mdl_err);
            check("rx_valid", rx_valid_o, (mdl_q.size() > 0));
            if (mdl_q.size() > 0) check("rx_head", rx_flit_o, mdl_q[0]);
            mon_pop  = (mdl_q.size() > 0) && rx_ready_i;
            mon_drop = 1'b0;
            if (mon_pop) void'(mdl_q.pop_front());
            if (local_flit_i[16]) begin
                mon_f = local_flit_i[15:0];
                if (mdl_q.size() >= DEPTH) mon_drop = 1'b1;
                else mdl_q.push_back(mon_f);
`ifdef NI_RX_CHECK_EN
                mon_bad = 1'b0;
                case (mon_f[15:14])
                    2'b01: begin
                        mon_bad    = (mon_f[13:10] != RID) || mdl_in_pkt;
                        mdl_in_pkt = (mon_f[5:3] != 0);
                    end
                    2'b10: mon_bad = !mdl_in_pkt;
                    2'b11: begin
                        mon_bad    = !mdl_in_pkt;
                        mdl_in_pkt = 1'b0;
                    end
                    default: mon_bad = 1'b1;
                endcase
                if (mon_bad && mdl_err < 255) mdl_err++;
`else
                mon_bad = 1'b0;
`endif
            end
            check("rx_drop", rx_drop_o, mon_drop);
            if (mon_drop) drop_cnt++;
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (tx_busy_o && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("wait_idle", tx_busy_o, 0);
    endtask

    // Pushes the expected flits, then issues the request; returns in the HEAD cycle.
    task automatic start_pkt(input logic [3:0] d, input logic [2:0] l);
        for (int i = 0; i < 8; i++) cur_pl[i] = 14'($urandom);
        tx_exp_q.push_back({1'b1, 2'b01, d, RID, l, 3'b000});
        for (int i = 0; i < int'(l); i++) begin
            tx_exp_q.push_back({1'b1, (i == int'(l) - 1) ? 2'b11 : 2'b10, cur_pl[i]});
        end
        wait_idle();
        pe_dest_i = d;
        pe_len_i  = l;
        pe_req_i  = 1'b1;
        @(negedge clk);
        pe_req_i  = 1'b0;
        pe_dest_i = 4'($urandom);
        pe_len_i  = 3'($urandom);
    endtask

    task automatic feed_body(input logic [2:0] l, input bit always_valid);
        int idx = 0;
        int n   = 0;
        while (idx < int'(l) && n < 400) begin
            pe_data_i  = cur_pl[idx];
            pe_valid_i = always_valid || ($urandom % 3 != 0);
            #1;
            if (pe_ready_o) idx++;
            @(negedge clk);
            n++;
        end
        pe_valid_i = 1'b0;
        check("body_done", idx, l);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    logic [16:0] exp_h;
    int          d0;
    logic [2:0]  rl;

    initial begin
        repeat (2) @(negedge clk);
        #1;
        check("rst_flit", local_flit_o, 0);
        check("rst_hs", {pe_ack_o, pe_ready_o, tx_busy_o}, 0);
        check("rst_rx", {rx_valid_o, rx_drop_o, rx_flit_o}, 0);
        check("rst_err", err_cnt_o, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Test 1: dest=5 len=3, no backpressure.
        local_full_i = 1'b0;
        start_pkt(4'd5, 3'd3);
        feed_body(3'd3, 1'b1);
        wait_idle();
        check("t1_head", last_head, 17'h15758);
        check("t1_consecutive", tail_cyc - head_cyc, 3);

        // Test 2: full held 4 cycles in HEAD.
        local_full_i = 1'b1;
        start_pkt(4'd9, 3'd1);
        for (int i = 0; i < 4; i++) begin
            #1;
            check("t2_ack_held", pe_ack_o, 0);
            check("t2_flit_held", local_flit_o, 0);
            @(negedge clk);
        end
        local_full_i = 1'b0;
        exp_h = {1'b1, 2'b01, 4'd9, RID, 3'd1, 3'b000};
        #1;
        check("t2_ack", pe_ack_o, 1);
        check("t2_head", local_flit_o, exp_h);
        @(negedge clk);
        feed_body(3'd1, 1'b1);
        wait_idle();

        // Test 3: header-only packet.
        start_pkt(4'd3, 3'd0);
        #1;
        check("t3_ack", pe_ack_o, 1);
        @(negedge clk);
        check("t3_busy", tx_busy_o, 0);

        // Random TX with random backpressure and PE stalls.
        rand_full = 1'b1;
        for (int p = 0; p < 12; p++) begin
            rl = 3'($urandom);
            start_pkt(4'($urandom), rl);
            feed_body(rl, 1'b0);
        end
        wait_idle();
        rand_full    = 1'b0;
        local_full_i = 1'b0;
        @(negedge clk);
        check("tx_q_empty", tx_exp_q.size(), 0);

        // Test 4: five pushes into a 4-deep FIFO with no pops.
        rx_ready_i = 1'b0;
        drop_cnt   = 0;
        for (int i = 0; i < 5; i++) begin
            local_flit_i = {1'b1, 16'($urandom)};
            @(negedge clk);
        end
        local_flit_i = '0;
        check("t4_drops", drop_cnt, 1);
        rx_ready_i = 1'b1;
        repeat (5) @(negedge clk);
        rx_ready_i = 1'b0;
        check("t4_empty", rx_valid_o, 0);

        // Test 5: full FIFO, push and pop in the same cycle.
        drop_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            local_flit_i = {1'b1, 16'($urandom)};
            @(negedge clk);
        end
        local_flit_i = {1'b1, 16'hBEEF};
        rx_ready_i   = 1'b1;
        @(negedge clk);
        local_flit_i = '0;
        rx_ready_i   = 1'b0;
        #1;
        check("t5_valid", rx_valid_o, 1);
        check("t5_nodrop", drop_cnt, 0);
        @(negedge clk);
        rx_ready_i = 1'b1;
        repeat (5) @(negedge clk);

        // Random RX traffic with random PE readiness.
        for (int i = 0; i < 300; i++) begin
            local_flit_i = ($urandom % 2 == 0) ? {1'b1, 16'($urandom)} : 17'h0;
            rx_ready_i   = ($urandom % 2 == 0);
            @(negedge clk);
        end
        local_flit_i = '0;
        rx_ready_i   = 1'b1;
        repeat (6) @(negedge clk);
        check("rx_drained", rx_valid_o, 0);

        // Test 7: reset mid-BODY with entries in the RX FIFO.
        rx_ready_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            local_flit_i = {1'b1, 16'($urandom)};
            @(negedge clk);
        end
        local_flit_i = '0;
        start_pkt(4'd7, 3'd5);
        pe_valid_i = 1'b0;
        @(negedge clk);
        pe_data_i  = cur_pl[0];
        pe_valid_i = 1'b1;
        @(negedge clk);
        check("t7_in_body", tx_busy_o, 1);
        pe_data_i  = cur_pl[1];
        rst        = 1'b0;
        #1;
        check("t7_flit", local_flit_o, 0);
        check("t7_hs", {pe_ack_o, pe_ready_o, tx_busy_o}, 0);
        check("t7_rx", {rx_valid_o, rx_drop_o}, 0);
        pe_valid_i = 1'b0;
        tx_exp_q.delete();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("t7_idle", tx_busy_o, 0);
        check("t7_fifo_empty", rx_valid_o, 0);

        // Test 6: bad-destination header then orphan BODY.
        rx_ready_i   = 1'b1;
        local_flit_i = {1'b1, 2'b01, 4'd2, 4'd7, 3'd0, 3'd0};
        @(negedge clk);
        local_flit_i = {1'b1, 2'b10, 14'h1234};
        @(negedge clk);
        local_flit_i = '0;
        @(negedge clk);
`ifdef NI_RX_CHECK_EN
        d0 = 2;
`else
        d0 = 0;
`endif
        check("t6_err", err_cnt_o, d0);
        repeat (3) @(negedge clk);
        check("final_tx_q", tx_exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
